// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, constants and arbitration helper for the demux channel buffer
package demux_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef logic chan_t;

    localparam chan_t CH0 = 1'b0;
    localparam chan_t CH1 = 1'b1;

    // Round-robin pick between two requesters. When both are ready the one
    // that was not served last wins; otherwise whichever is ready is served.
    function automatic chan_t rr_pick(input logic avail_0, input logic avail_1, input chan_t last);
        if (avail_0 && avail_1) begin
            return (last == CH0) ? CH1 : CH0;
        end else if (avail_1) begin
            return CH1;
        end else begin
            return CH0;
        end
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// rtl/chan_fifo.sv - single-clock per-channel FIFO with registered count
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   push, din  write request and data; ignored while full
//   pop, dout  read request; dout shows the head entry whenever not empty
//   count      number of stored entries (0..DEPTH)
//   full       count == DEPTH
//   empty      count == 0
module chan_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full/empty come from the count before the edge, so a push into a full
    // FIFO is dropped even when a pop happens on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset: entries are only visible through valid counts.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits and wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_chan_buffer.sv
// rtl/demux_chan_buffer.sv - two-channel receive buffer merging demux outputs round-robin
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid, in_sel         byte present on the selected demux output; select 0/1
//   in_data_0, in_data_1     demux outputs; only in_data_<in_sel> is captured
//   in_ready_0, in_ready_1   channel FIFO not full (from registered counts)
//   out_valid, out_ready     merged output handshake
//   out_data, out_chan       merged byte and its source channel
//   ovf_0, ovf_1             sticky overflow flags
//   clear_ovf                synchronous clear of both overflow flags
module demux_chan_buffer
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    output logic              in_ready_0,
    output logic              in_ready_1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_chan,
    output logic              ovf_0,
    output logic              ovf_1,
    input  logic              clear_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] dout_0;
    logic [DATA_W-1:0] dout_1;
    logic [CW-1:0]     count_0;
    logic [CW-1:0]     count_1;
    logic              full_0;
    logic              full_1;
    logic              empty_0;
    logic              empty_1;

    logic              push_0;
    logic              push_1;
    logic              pop_0;
    logic              pop_1;
    logic              ovf_set_0;
    logic              ovf_set_1;
    logic              load;
    chan_t             grant;
    chan_t             last_served;

    // Write side: the demux select decides which FIFO sees the byte.
    assign push_0 = in_valid & (in_sel == CH0);
    assign push_1 = in_valid & (in_sel == CH1);

    assign ovf_set_0 = push_0 & full_0;
    assign ovf_set_1 = push_1 & full_1;

    assign in_ready_0 = (count_0 != FULL_CNT);
    assign in_ready_1 = (count_1 != FULL_CNT);

    // The output stage refills when it is empty or being drained this edge.
    assign load  = (~out_valid | out_ready) & (~empty_0 | ~empty_1);
    assign grant = rr_pick(~empty_0, ~empty_1, last_served);
    assign pop_0 = load & (grant == CH0);
    assign pop_1 = load & (grant == CH1);

    chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push_0),
        .pop   (pop_0),
        .din   (in_data_0),
        .dout  (dout_0),
        .count (count_0),
        .full  (full_0),
        .empty (empty_0)
    );

    chan_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push_1),
        .pop   (pop_1),
        .din   (in_data_1),
        .dout  (dout_1),
        .count (count_1),
        .full  (full_1),
        .empty (empty_1)
    );

    // Output register plus the round-robin memory. last_served starts at CH1
    // so that channel 0 wins the first contended arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_chan    <= CH0;
            last_served <= CH1;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_data    <= (grant == CH1) ? dout_1 : dout_0;
            out_chan    <= grant;
            last_served <= grant;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Sticky overflow flags; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_0 <= 1'b0;
            ovf_1 <= 1'b0;
        end else begin
            if (ovf_set_0) begin
                ovf_0 <= 1'b1;
            end else if (clear_ovf) begin
                ovf_0 <= 1'b0;
            end
            if (ovf_set_1) begin
                ovf_1 <= 1'b1;
            end else if (clear_ovf) begin
                ovf_1 <= 1'b0;
            end
        end
    end

endmodule
